// File: rtl/dpram_port_initiator.sv
// Request-side engine for one dual-port RAM port: upstream command channel in,
// RAM port valid/ready out, read responses back on a downstream channel.
//
// state   | meaning
// IDLE    | ready for a command (cmd_ready=1)
// REQ     | driving mem_valid, waiting for mem_ready or watchdog abort
// RD_WAIT | read handshake done, mem_q lands at the next edge
// RSP     | read response (or aborted-read error) held until rsp_ready
module dpram_port_initiator #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  timeout_pulse,
    output logic [15:0]           wr_cnt,
    output logic [15:0]           rd_cnt
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RD_WAIT = 2'd2,
        RSP     = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic cmd_fire, mem_fire, abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_fire  = 1'b0;
        mem_fire  = 1'b0;
        abort     = 1'b0;
        cmd_ready = (state == IDLE);
        mem_valid = (state == REQ);
        rsp_valid = (state == RSP);
        case (state)
            IDLE: begin
                cmd_fire = cmd_valid;
                if (cmd_valid) state_nxt = REQ;
            end
            REQ: begin
                // Down-counter hitting zero while still stalled is the
                // TIMEOUT-th low cycle; a late mem_ready still wins.
                mem_fire = mem_ready;
                abort    = !mem_ready && (wd_cnt == '0);
                if (mem_fire || abort) state_nxt = mem_we ? IDLE : (mem_fire ? RD_WAIT : RSP);
            end
            RD_WAIT: state_nxt = RSP;
            RSP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_data      <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            timeout_pulse <= 1'b0;
            wd_cnt        <= '0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
        end else begin
            timeout_pulse <= abort;
            if (cmd_fire) begin
                mem_we   <= cmd_we;
                mem_addr <= cmd_addr;
                mem_data <= cmd_data;
                wd_cnt   <= WD_LOAD;
            end else if (state == REQ && !mem_ready && wd_cnt != '0) begin
                wd_cnt <= wd_cnt - 1'b1;
            end
            if (mem_fire && mem_we)
                wr_cnt <= wr_cnt + 16'd1;
            if (state == RD_WAIT) begin
                rsp_data <= mem_q;
                rsp_err  <= 1'b0;
                rd_cnt   <= rd_cnt + 16'd1;
            end else if (abort && !mem_we) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dpram_port_initiator.sv
// Directed bench for dpram_port_initiator with a small registered-read RAM model
// on the port side; one task per scenario, checks inline.
module tb_dpram_port_initiator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [5:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       mem_valid, mem_ready = 1'b1, mem_we;
    logic [5:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] mem_q = '0;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_err, timeout_pulse;
    logic [7:0] rsp_data;
    logic [15:0] wr_cnt, rd_cnt;
    logic [7:0] ram [0:63];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dpram_port_initiator #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .timeout_pulse(timeout_pulse),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    // RAM port model: write on handshake, read data registered one cycle later
    always @(posedge clk) begin
        if (mem_valid && mem_ready) begin
            if (mem_we) ram[mem_addr] <= mem_data;
            else        mem_q <= ram[mem_addr];
        end
    end

    // Present a command at a negedge; returns just after the accepting edge.
    task automatic issue(input logic we, input logic [5:0] addr, input logic [7:0] data);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_data = data;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
        total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || timeout_pulse !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b%b exp=000", rsp_valid, rsp_err, timeout_pulse); end
        total++; if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%h/%h exp=0/0", wr_cnt, rd_cnt); end
        total++; if (mem_addr !== 6'd0 || mem_data !== 8'd0 || rsp_data !== 8'd0) begin bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", mem_addr, mem_data, rsp_data); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_write();
        mem_ready = 1'b1;
        issue(1'b1, 6'h05, 8'hA5);
        @(negedge clk);
        total++; if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'h05 || mem_data !== 8'hA5)
            begin bad++; $display("FAIL wr_req got=v%b we%b a%h d%h exp=v1 we1 a05 dA5", mem_valid, mem_we, mem_addr, mem_data); end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL wr_busy got=%b exp=0", cmd_ready); end
        @(negedge clk);
        total++; if (mem_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_done got=v%b r%b exp=v0 r1", mem_valid, cmd_ready); end
        total++; if (wr_cnt !== 16'd1) begin bad++; $display("FAIL wr_cnt got=%0d exp=1", wr_cnt); end
    endtask

    task automatic test_read();
        mem_ready = 1'b1; rsp_ready = 1'b1;
        issue(1'b0, 6'h05, 8'h00);
        @(negedge clk);
        total++; if (mem_valid !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL rd_req got=v%b we%b exp=v1 we0", mem_valid, mem_we); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || mem_valid !== 1'b0) begin bad++; $display("FAIL rd_wait got=rv%b mv%b exp=0 0", rsp_valid, mem_valid); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5 || rsp_err !== 1'b0)
            begin bad++; $display("FAIL rd_rsp got=v%b d%h e%b exp=v1 dA5 e0", rsp_valid, rsp_data, rsp_err); end
        total++; if (rd_cnt !== 16'd1) begin bad++; $display("FAIL rd_cnt got=%0d exp=1", rd_cnt); end
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_done got=r%b v%b exp=r1 v0", cmd_ready, rsp_valid); end
    endtask

    // ready low for low_cycles of REQ, then high; expects low_cycles+1 cycles of mem_valid and no abort
    task automatic test_stall(input int low_cycles, input logic [5:0] addr, input logic [7:0] data, input logic [15:0] exp_wr);
        int n = 0, pulses = 0;
        logic stable = 1'b1;
        mem_ready = 1'b0;
        issue(1'b1, addr, data);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (timeout_pulse) pulses++;
            if (mem_valid) begin
                n++;
                if (mem_we !== 1'b1 || mem_addr !== addr || mem_data !== data) stable = 1'b0;
                if (n == low_cycles + 1) mem_ready = 1'b1;
            end else if (n > 0) break;
        end
        total++; if (n != low_cycles + 1) begin bad++; $display("FAIL stall_len got=%0d exp=%0d", n, low_cycles + 1); end
        total++; if (!stable) begin bad++; $display("FAIL stall_stable got=unstable exp=stable"); end
        total++; if (pulses != 0) begin bad++; $display("FAIL stall_no_timeout got=%0d exp=0", pulses); end
        total++; if (wr_cnt !== exp_wr || cmd_ready !== 1'b1) begin bad++; $display("FAIL stall_done got=w%0d r%b exp=w%0d r1", wr_cnt, cmd_ready, exp_wr); end
    endtask

    task automatic test_timeout();
        int n = 0, pulses = 0;
        logic seen = 1'b0;
        mem_ready = 1'b0; rsp_ready = 1'b0;
        issue(1'b0, 6'h07, 8'h00);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (timeout_pulse) pulses++;
            if (mem_valid) n++;
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL to_rsp got=no_rsp exp=rsp"); end
        total++; if (n != 16) begin bad++; $display("FAIL to_len got=%0d exp=16", n); end
        total++; if (rsp_err !== 1'b1 || rsp_data !== 8'h00) begin bad++; $display("FAIL to_err got=e%b d%h exp=e1 d00", rsp_err, rsp_data); end
        @(negedge clk);
        if (timeout_pulse) pulses++;
        total++; if (pulses != 1) begin bad++; $display("FAIL to_pulses got=%0d exp=1", pulses); end
        total++; if (rd_cnt !== 16'd1) begin bad++; $display("FAIL to_rd_cnt got=%0d exp=1", rd_cnt); end
        rsp_ready = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL to_done got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_backpressure();
        logic ok = 1'b1;
        mem_ready = 1'b1; rsp_ready = 1'b0;
        issue(1'b0, 6'h05, 8'h00);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 6'h10; cmd_data = 8'h77;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 8'hA5 || mem_valid !== 1'b0) ok = 1'b0;
            if (i < 3) @(negedge clk);
        end
        total++; if (!ok) begin bad++; $display("FAIL bp_hold got=r%b v%b d%h exp=r0 v1 dA5", cmd_ready, rsp_valid, rsp_data); end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1 || mem_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=r%b mv%b exp=r1 mv0", cmd_ready, mem_valid); end
        @(negedge clk);
        cmd_valid = 1'b0;
        total++; if (mem_valid !== 1'b1 || mem_addr !== 6'h10 || mem_data !== 8'h77)
            begin bad++; $display("FAIL bp_next got=v%b a%h d%h exp=v1 a10 d77", mem_valid, mem_addr, mem_data); end
        @(negedge clk);
        total++; if (wr_cnt !== 16'd4 || rd_cnt !== 16'd2) begin bad++; $display("FAIL bp_cnt got=%0d/%0d exp=4/2", wr_cnt, rd_cnt); end
    endtask

    task automatic test_mid_reset();
        int rsps = 0;
        mem_ready = 1'b0;
        issue(1'b1, 6'h3F, 8'h5A);
        repeat (3) @(negedge clk);
        total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL mr_in_req got=%b exp=1", mem_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (mem_valid !== 1'b0 || wr_cnt !== 16'd0 || rd_cnt !== 16'd0 || mem_addr !== 6'd0)
            begin bad++; $display("FAIL mr_async got=v%b w%0d r%0d a%h exp=v0 w0 r0 a00", mem_valid, wr_cnt, rd_cnt, mem_addr); end
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) rsps++;
        end
        total++; if (rsps != 0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL mr_no_rsp got=%0d r%b exp=0 r1", rsps, cmd_ready); end
        issue(1'b1, 6'h3F, 8'h5A);
        repeat (2) @(negedge clk);
        total++; if (wr_cnt !== 16'd1 || cmd_ready !== 1'b1) begin bad++; $display("FAIL mr_after_wr got=w%0d r%b exp=w1 r1", wr_cnt, cmd_ready); end
        rsp_ready = 1'b1;
        issue(1'b0, 6'h3F, 8'h00);
        repeat (3) @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A || rd_cnt !== 16'd1)
            begin bad++; $display("FAIL mr_after_rd got=v%b d%h c%0d exp=v1 d5A c1", rsp_valid, rsp_data, rd_cnt); end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_stall(5, 6'h2A, 8'h3C, 16'd2);
        test_timeout();
        test_stall(15, 6'h11, 8'hC3, 16'd3);
        test_backpressure();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/dpram_port_initiator.md
# dpram_port_initiator

Request-side engine for one port of the dual-port RAM (`dpram`): accepts read/write commands on an upstream valid/ready channel and drives the RAM port's `valid/we/addr/data` signals. It waits for `ready`, captures `q` for reads and returns read responses on a downstream valid/ready channel. Two instances, one per port, replace bench-driven port stimulus in subsystem builds. Each instance includes a ready-timeout watchdog and completion counters.

## Interface
- `DATA_WIDTH`, 8, width of write data, read data and `q`
- `ADDR_WIDTH`, 6, RAM address width
- `TIMEOUT`, 16, consecutive cycles of `mem_ready` low in REQ before the request is aborted (≥2)
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `cmd_valid`  in  1  upstream command valid
- `cmd_ready`  out  1  initiator can accept a command
- `cmd_we`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_WIDTH  command address
- `cmd_data`  in  DATA_WIDTH  write data (ignored for reads)
- `mem_valid`  out  1  to RAM port `valid`
- `mem_ready`  in  1  from RAM port `ready`
- `mem_we`  out  1  to RAM port `we`
- `mem_addr`  out  ADDR_WIDTH  to RAM port `addr`
- `mem_data`  out  DATA_WIDTH  to RAM port `data`
- `mem_q`  in  DATA_WIDTH  from RAM port `q`
- `rsp_valid`  out  1  read response valid
- `rsp_ready`  in  1  downstream accepts response
- `rsp_data`  out  DATA_WIDTH  read data
- `rsp_err`  out  1  response belongs to an aborted (timed-out) read
- `timeout_pulse`  out  1  one-cycle pulse on any abort
- `wr_cnt`, `rd_cnt`  out  16 each  completed write / read handshakes, wrap 0xFFFF→0; aborts not counted

## Operation
- FSM states: IDLE, REQ, RD_WAIT, RSP.
- IDLE:
  - `cmd_ready`=1 only in IDLE.
  - On `cmd_valid&cmd_ready`, register we/addr/data into the `mem_*` outputs and go to REQ.
- REQ:
  - `mem_valid`=1. `mem_we/addr/data` are held stable until the handshake or an abort.
  - On `mem_valid&mem_ready`: a write increments `wr_cnt` and returns to IDLE; a read goes to RD_WAIT.
- RD_WAIT:
  - `mem_valid`=0.
  - At the next edge, capture `mem_q` into `rsp_data`, set `rsp_err`=0, increment `rd_cnt`, go to RSP.
- RSP:
  - `rsp_valid`=1. `rsp_data` and `rsp_err` are held stable until `rsp_valid&rsp_ready`, then return to IDLE.
  - No new command is accepted while a response is pending (one outstanding transaction).
- Watchdog:
  - The counter clears on entry to REQ and increments on each REQ cycle with `mem_ready`=0.
  - When the count reaches TIMEOUT with `mem_ready` still low, the abort happens in that cycle: `mem_valid` drops at the next edge and `timeout_pulse`=1 for one cycle.
  - Aborted write: go to IDLE.
  - Aborted read: go to RSP with `rsp_data`=0 and `rsp_err`=1.
  - If `mem_ready` rises in the same cycle the count reaches TIMEOUT, the handshake wins and no abort occurs.
- `mem_we`, `mem_addr` and `mem_data` are don't-care outside REQ but are held at the last value (no toggling).
- Reset, asynchronous and valid at any state: FSM→IDLE; `cmd_ready`=1 after release; `mem_valid`, `mem_we`, `rsp_valid`, `rsp_err`, `timeout_pulse`=0; `mem_addr`, `mem_data`, `rsp_data`=0; counters=0; watchdog=0. Any in-flight transaction is dropped without a response.

## Timing
- Command accepted at edge N → `mem_valid`=1 during cycle N+1.
- Write with `mem_ready` already high: handshake at edge N+1, `cmd_ready` high in cycle N+2. Best-case write throughput is 1 per 2 cycles.
- Read with `mem_ready` already high: handshake at N+1, `mem_q` sampled at N+2, `rsp_valid` in cycle N+3. With `rsp_ready`=1, `cmd_ready` is high in N+4.
- `mem_q` must be valid exactly one cycle after the read handshake edge. This is the RAM port's registered-read contract.
- `wr_cnt` updates at the write handshake edge. `rd_cnt` updates at the RD_WAIT→RSP edge.
- Abort: the abort happens in the cycle where the count reaches TIMEOUT; `mem_valid` falls at the following edge.

## Test plan
- Write addr 0x05 data 0xA5, `mem_ready` tied 1 → `mem_valid` high exactly 1 cycle with addr 0x05, we=1, data 0xA5; `wr_cnt`=1; `cmd_ready` back 2 cycles after accept.
- Read addr 0x05 after that write, against a live `dpram` → `rsp_valid` 3 cycles after accept, `rsp_data`=0xA5, `rsp_err`=0, `rd_cnt`=1.
- `mem_ready` held low 5 cycles then high → `mem_addr/data/we` stable for all 6 cycles of `mem_valid`; no timeout.
- `mem_ready` stuck low, TIMEOUT=16, read cmd → one `timeout_pulse`; `rsp_valid` with `rsp_err`=1 and `rsp_data`=0; `rd_cnt` unchanged.
- `rsp_ready` low 4 cycles while `cmd_valid` stays high → `cmd_ready`=0 and `rsp_data` stable throughout; next command accepted only after the response handshake.
- Assert `rst` mid-REQ → `mem_valid`=0 immediately (asynchronous), counters 0, no response; the next command after release completes normally.
